led_frame_buffer: RTL

LED_FRAME_BUFFER -- requirements
Module: led_frame_buffer

---
 rtl/led_frame_buffer.sv | 98 +++++++++
 1 files changed

// File: rtl/led_frame_buffer.sv
// Double-buffered LED frame store. The host fills the back bank while the
// display bank streams out byte by byte. A requested swap is deferred until
// the read pointer wraps, so a frame is never torn. Brightness is shadowed
// and changes together with the bank swap.
//
// state   | meaning
// IDLE    | no swap requested; a wrap repeats the current frame
// PENDING | swap requested; the next wrap flips banks and brightness
module led_frame_buffer #(
  parameter int          DEPTH       = 64,
  parameter int          AW          = 6,
  parameter logic [7:0]  BRIGHT_INIT = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          bright_we,
  input  logic [7:0]    bright_in,
  input  logic          swap_req,
  input  logic          advance,
  output logic [7:0]    led_vals,
  output logic [7:0]    brightness,
  output logic          frame_start,
  output logic          swap_pending,
  output logic          swap_done
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    mem [0:2*DEPTH-1];
  logic [AW-1:0] rd_ptr;
  logic          disp_bank;
  logic [7:0]    shadow;
  logic          wrap;
  logic          do_swap;

  assign wrap        = advance && (rd_ptr == AW'(DEPTH - 1));
  assign frame_start = (rd_ptr == '0);

  // Swap FSM next state; a request coinciding with a wrap is taken immediately.
  always_comb begin
    state_nxt    = state;
    do_swap      = 1'b0;
    swap_pending = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req && wrap) do_swap = 1'b1;
        else if (swap_req)    state_nxt = PENDING;
      end
      PENDING: begin
        swap_pending = 1'b1;
        if (wrap) begin
          do_swap   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Swap FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Host writes always target the bank that is not being displayed; no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{~disp_bank, wr_addr}] <= wr_data;
  end

  // Read pointer, bank select, brightness shadow and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      disp_bank  <= 1'b0;
      swap_done  <= 1'b0;
      led_vals   <= 8'h00;
      brightness <= BRIGHT_INIT;
      shadow     <= BRIGHT_INIT;
    end else begin
      led_vals  <= mem[{disp_bank, rd_ptr}];
      swap_done <= do_swap;
      if (advance) rd_ptr <= rd_ptr + AW'(1);
      if (do_swap) begin
        disp_bank  <= ~disp_bank;
        brightness <= shadow;
      end
      // Shadow load after the copy above: a load in the swap cycle waits for the next swap.
      if (bright_we) shadow <= bright_in;
    end
  end

endmodule
